// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers bit and group propagate/generate; stage 2 resolves carries and sums.
module cla_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NumGroups = WIDTH / GROUP;

  // Handshake state
  logic s1_v_q, s2_v_q;
  logic s2_free, in_fire, s1_load, s1_drain, s2_load, out_fire;

  // Stage 1 next-state and registers
  logic [WIDTH-1:0]     b_eff;
  logic [WIDTH-1:0]     p_d, g_d, p_q, g_q;
  logic [NumGroups-1:0] gp_d, gg_d, gp_q, gg_q;
  logic                 c0_d, c0_q;

  // Stage 2 next-state and registers
  logic [NumGroups:0]   grp_c;
  logic [WIDTH:0]       bit_c;
  logic [WIDTH-1:0]     sum_d, sum_q;
  logic                 cout_d, cout_q, ovf_d, ovf_q;

  // Flow control
  always_comb begin
    s2_free  = ~s2_v_q | out_ready;
    in_ready = ~s1_v_q | s2_free;
    in_fire  = in_valid & in_ready;
    out_fire = s2_v_q & out_ready;
    s1_load  = in_fire;
    s1_drain = s1_v_q & s2_free;
    s2_load  = s1_v_q & s2_free;
  end

  // Stage 1: effective operands and P/G terms
  always_comb begin
    b_eff = sub ? ~y : y;
    c0_d  = sub | cin;
    p_d   = x ^ b_eff;
    g_d   = x & b_eff;
    gp_d  = '1;
    gg_d  = '0;
    for (int k = 0; k < int'(NumGroups); k++) begin
      for (int j = 0; j < int'(GROUP); j++) begin
        // Fold from LSB upward so the top bit's generate dominates.
        gg_d[k] = g_d[k*GROUP + j] | (p_d[k*GROUP + j] & gg_d[k]);
        gp_d[k] = gp_d[k] & p_d[k*GROUP + j];
      end
    end
  end

  // Stage 2: group carries, then ripple inside each group from its group carry-in
  always_comb begin
    grp_c    = '0;
    grp_c[0] = c0_q;
    for (int k = 0; k < int'(NumGroups); k++) begin
      grp_c[k+1] = gg_q[k] | (gp_q[k] & grp_c[k]);
    end
    bit_c = '0;
    for (int k = 0; k < int'(NumGroups); k++) begin
      bit_c[k*GROUP] = grp_c[k];
      for (int j = 0; j < int'(GROUP) - 1; j++) begin
        bit_c[k*GROUP + j + 1] = g_q[k*GROUP + j] | (p_q[k*GROUP + j] & bit_c[k*GROUP + j]);
      end
    end
    bit_c[WIDTH] = grp_c[NumGroups];
    sum_d  = p_q ^ bit_c[WIDTH-1:0];
    cout_d = bit_c[WIDTH];
    ovf_d  = bit_c[WIDTH-1] ^ bit_c[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      p_q    <= '0;
      g_q    <= '0;
      gp_q   <= '0;
      gg_q   <= '0;
      c0_q   <= 1'b0;
    end else if (s1_load) begin
      s1_v_q <= 1'b1;
      p_q    <= p_d;
      g_q    <= g_d;
      gp_q   <= gp_d;
      gg_q   <= gg_d;
      c0_q   <= c0_d;
    end else if (s1_drain) begin
      s1_v_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (s2_load) begin
      s2_v_q <= 1'b1;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end else if (out_fire) begin
      s2_v_q <= 1'b0;
    end
  end

  always_comb begin
    out_valid = s2_v_q;
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Randomised and directed bench for cla_adder_pipe; results are scored against an
// arithmetic model held in an in-order queue.
module tb_cla_adder_pipe;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_vld  = 0;
  logic [W+1:0] exp_q[$];

  cla_adder_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: {cout, ovf, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] bb,
                                         input logic ci, input logic s);
    logic [W-1:0] be;
    logic [W:0]   r;
    logic         ov;
    be = s ? ~bb : bb;
    r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    ov = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    return {r[W], ov, r[W-1:0]};
  endfunction

  // Scoreboard: front of queue must be on the outputs whenever out_valid is high.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        n_vld++;
        if (exp_q.size() == 0) begin
          check("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          check("sb_sum", {16'd0, sum}, {16'd0, exp_q[0][W-1:0]});
          check("sb_cout", {31'd0, cout}, {31'd0, exp_q[0][W+1]});
          check("sb_ovf", {31'd0, ovf}, {31'd0, exp_q[0][W]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(x, y, cin, sub));
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] bb,
                       input logic ci, input logic s);
    in_valid = 1'b1;
    x = a;
    y = bb;
    cin = ci;
    sub = s;
  endtask

  // Single op with out_ready=1; result checked one cycle after acceptance.
  task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] bb,
                          input logic ci, input logic s, input logic [W-1:0] esum,
                          input logic ecout, input logic eovf);
    out_ready = 1'b1;
    drive(a, bb, ci, s);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n;
    out_ready = 1'b1;
    in_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    // Reset state
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed arithmetic cases
    op_check("t1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op_check("t2a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op_check("t2b", 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
    op_check("t3a", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op_check("t3b", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back throughput, then a one-cycle bubble
    out_ready = 1'b1;
    base = n_out;
    for (int i = 1; i <= 4; i++) begin
      drive(i[W-1:0], i[W-1:0], 1'b0, 1'b0);
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      if (i >= 2) check("b2b_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_valid_last", {31'd0, out_valid}, 32'd1);
    check("b2b_sum_last", {16'd0, sum}, 32'h0008);
    @(posedge clk); #1;
    check("b2b_bubble", {31'd0, out_valid}, 32'd0);
    check("b2b_count", n_out - base, 32'd4);

    // Stall with a full pipeline
    out_ready = 1'b0;
    base = n_out;
    drive(16'h0010, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h0020, 16'h0002, 1'b0, 1'b0);
    check("stall_2nd_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drive(16'h0030, 16'h0003, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_hold_sum", {16'd0, sum}, 32'h0011);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("stall");
    check("stall_count", n_out - base, 32'd3);

    // Asynchronous reset with two ops in flight
    out_ready = 1'b0;
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h3333, 16'h4444, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_sum", {16'd0, sum}, 32'd0);
    check("arst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    base = n_vld;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_stale", n_vld - base, 32'd0);

    // Randomised traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cla_adder_pipe.md
# cla_adder_pipe

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output. It generalises the bitwise propagate/generate unit to WIDTH bits grouped into GROUP-bit lookahead blocks. Stage 1 registers bit and group P/G terms. Stage 2 resolves group carries and sums. It sits between operand-producing logic and any consumer that may apply backpressure, and sustains one result per cycle.

## Interface
- WIDTH, 16, operand/sum width; must be ≥2 and a multiple of GROUP
- GROUP, 4, bits per lookahead group; must be ≥1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept an operand set this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result this cycle
- sum  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow

## Operation
- Effective operands:
  - b = sub ? ~y : y
  - c0 = sub ? 1 : cin. In subtract mode cin is ignored.
- Stage 1 captures, per bit:
  - p[i] = x[i]^b[i]
  - g[i] = x[i]&b[i]
- Stage 1 also captures, per group k:
  - group propagate P[k] = AND of p in the group
  - group generate G[k] = standard lookahead fold of g/p within the group
- Stage 1 holds c0 and a valid bit s1_v.
- Stage 2 logic:
  - Group carry-in: C[k+1] = G[k] | P[k]&C[k], with C[0] = c0.
  - In-group carry: c[i+1] = g[i] | p[i]&c[i], seeded by C[k].
  - sum[i] = p[i]^c[i]
  - cout = c[WIDTH]
  - ovf = c[WIDTH-1]^c[WIDTH]
- Stage 2 registers sum, cout and ovf, with a valid bit s2_v.
- Handshake / flow:
  - s2_free = !s2_v | out_ready
  - in_ready = !s1_v | s2_free (combinational; no dependency on in_valid)
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - Stage 1 loads on input transfer.
  - Otherwise, if s2_free and s1_v, stage 1 empties: s1_v ← 0.
  - Stage 2 loads from stage 1 when s1_v & s2_free.
  - Otherwise, on output transfer, s2_v ← 0.
  - Simultaneous input transfer and stage 1→2 move are allowed (full throughput).
  - While out_valid=1 and out_ready=0, sum, cout and ovf are held stable.
  - Results leave in acceptance order; none are dropped or duplicated.
  - x, y, cin and sub are sampled only on an input transfer.
- out_valid = s2_v.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - s1_v, s2_v and out_valid to 0
  - sum to 0, cout to 0, ovf to 0
  - all stage 1 P/G registers to 0
- After reset, in_ready = 1.
- Reset mid-operation discards every in-flight result. Following deassertion, no result for those operands is ever emitted.
- Latency: operands accepted at edge N give out_valid=1 after edge N+1, provided out_ready was not stalling stage 2.
- Throughput is 1 result/cycle with out_ready held 1.
- Full pipeline (s1_v=s2_v=1) with out_ready=0 gives in_ready=0. in_ready returns to 1 in the same cycle out_ready rises.
- A bubble on in_valid propagates as out_valid=0 for exactly one cycle.
- The carry path is purely within stage 2. There is no combinational path from x/y to any output.

## Test plan
Parameters WIDTH=16, GROUP=4.
1. Reset, then x=0xFFFF, y=0x0001, cin=0, sub=0, out_ready=1 → one cycle after acceptance: sum=0x0000, cout=1, ovf=0.
2. x=0x7FFF, y=0x0001, cin=0, add → sum=0x8000, cout=0, ovf=1. Also x=0x1234, y=0x0000, cin=1 → sum=0x1235, cout=0, ovf=0.
3. sub=1, x=0x0005, y=0x0007, cin=1 → sum=0xFFFE, cout=0, ovf=0. Also sub=1, x=0x8000, y=0x0001 → sum=0x7FFF, cout=1, ovf=1.
4. Four back-to-back adds (1+1, 2+2, 3+3, 4+4) with out_ready=1 → in_ready stays 1; out_valid=1 for 4 consecutive cycles; sums 0x0002, 0x0004, 0x0006, 0x0008 in order.
5. Stall: issue 3 ops with out_ready=0 → first two accepted, then in_ready=0. sum holds the first result stable while stalled. Raise out_ready → all three results emerge in order, with no loss or duplicates.
6. Reset mid-operation: assert rst_n=0 asynchronously (between edges) with two ops in flight → out_valid, sum, cout and ovf are 0 immediately. After release, no stale results appear and in_ready=1.
